// File: rtl/rob_pkg.sv
// +------------------------------------------------------------------+
// | rob_pkg                                                          |
// | Helpers shared by the reorder buffer files.                      |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`default_nettype none

package rob_pkg;

    localparam int PERF_W = 32;

    // Saturating increment for the performance counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rob_alloc.sv
// +------------------------------------------------------------------+
// | rob_alloc                                                        |
// | Prefix-sum allocator: hands consecutive indices from tail to the |
// | valid dispatch lanes in ascending lane order.                    |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`include "sys_defs.svh"
`default_nettype none

module rob_alloc
    import rob_pkg::*;
#(
    parameter int N     = `N,
    parameter int DEPTH = `ROB_SZ
) (
    input  logic [N-1:0]          dispatch_valid,
    input  ROB_IDX                tail,
    output ROB_IDX                idxs [N],
    output logic [$clog2(DEPTH):0] dispatched
);

    // Running count of valid lanes below each lane gives its offset from tail;
    // invalid lanes are left at zero and consume nothing.
    always_comb begin
        dispatched = '0;
        for (int i = 0; i < N; i++) begin
            idxs[i] = '0;
            if (dispatch_valid[i]) begin
                idxs[i]    = tail + ROB_IDX'(dispatched);
                dispatched = dispatched + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sys_defs.svh
// +------------------------------------------------------------------+
// | sys_defs.svh                                                     |
// | Shared machine-wide definitions: window width, ROB size, address |
// | type, ROB index type and the ROB entry record.                   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`default_nettype none

`ifndef N
`define N 3
`endif

`ifndef ROB_SZ
`define ROB_SZ 8
`endif

typedef logic [31:0] ADDR;

typedef logic [$clog2(`ROB_SZ)-1:0] ROB_IDX;

typedef struct packed {
    logic       valid;
    logic       complete;
    logic       branch_taken;
    ADDR        branch_target;
    ADDR        pc;
    logic [4:0] dest_reg;
} ROB_ENTRY;

`default_nettype wire
`endif

// File: rtl/rob.sv
// +------------------------------------------------------------------+
// | rob                                                              |
// | Circular reorder buffer with N-wide dispatch, completion and     |
// | in-order retire window, plus flush on mispredict.                |
// | Optional feature macro: ROB_PERF_CNT_EN (performance counters).  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`include "sys_defs.svh"
`default_nettype none

module rob
    import rob_pkg::*;
#(
    parameter int N     = `N,
    parameter int DEPTH = `ROB_SZ
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           dispatch_valid,
    input  ROB_ENTRY               dispatch_entries [N],
    output logic                   dispatch_ready,
    output ROB_IDX                 dispatch_idxs [N],
    output logic [$clog2(DEPTH):0] free_slots,
    input  logic [N-1:0]           complete_valid,
    input  ROB_IDX                 complete_idxs [N],
    input  logic [N-1:0]           complete_taken,
    input  ADDR                    complete_target [N],
    output ROB_ENTRY               head_entries [N],
    output logic [N-1:0]           head_valids,
    output ROB_IDX                 head_idxs [N],
    input  logic                   mispredict,
    input  ROB_IDX                 mispred_idx,
    output logic [31:0]            perf_full_cycles,
    output logic [31:0]            perf_flushes
);

    localparam int CW = $clog2(DEPTH) + 1;

    ROB_ENTRY        entries [DEPTH];
    ROB_IDX          head;
    ROB_IDX          tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   dispatched;
    logic [CW-1:0]   retired;
    logic            retire_stop;
    logic            accept;
    ROB_ENTRY        alloc_entries [N];

    rob_alloc #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_alloc (
        .dispatch_valid (dispatch_valid),
        .tail           (tail),
        .idxs           (dispatch_idxs),
        .dispatched     (dispatched)
    );

    // Readiness looks only at registered occupancy, never at same-cycle retires.
    assign free_slots     = CW'(DEPTH) - count;
    assign dispatch_ready = (free_slots >= CW'(N));
    assign accept         = dispatch_ready && !mispredict;

    generate
        for (genvar w = 0; w < N; w++) begin : g_head
            assign head_idxs[w]    = head + ROB_IDX'(w);
            assign head_valids[w]  = (CW'(w) < count);
            assign head_entries[w] = head_valids[w] ? entries[head_idxs[w]] : '0;
        end
    endgenerate

    // New entries always enter as valid and not yet complete.
    always_comb begin
        for (int l = 0; l < N; l++) begin
            alloc_entries[l]          = dispatch_entries[l];
            alloc_entries[l].valid    = 1'b1;
            alloc_entries[l].complete = 1'b0;
        end
    end

    // Retire the leading run of valid, complete head slots.
    always_comb begin
        retired     = '0;
        retire_stop = 1'b0;
        for (int w = 0; w < N; w++) begin
            if (!retire_stop && head_valids[w] && head_entries[w].complete) begin
                retired = retired + 1'b1;
            end else begin
                retire_stop = 1'b1;
            end
        end
    end

    // Storage and pointer update; later lanes win on duplicate completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispredict) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid    <= 1'b0;
                entries[i].complete <= 1'b0;
            end
            head  <= mispred_idx + 1'b1;
            tail  <= mispred_idx + 1'b1;
            count <= '0;
        end else begin
            for (int l = 0; l < N; l++) begin
                if (complete_valid[l] && entries[complete_idxs[l]].valid) begin
                    entries[complete_idxs[l]].complete      <= 1'b1;
                    entries[complete_idxs[l]].branch_taken  <= complete_taken[l];
                    entries[complete_idxs[l]].branch_target <= complete_target[l];
                end
            end
            for (int w = 0; w < N; w++) begin
                if (CW'(w) < retired) begin
                    entries[head_idxs[w]].valid    <= 1'b0;
                    entries[head_idxs[w]].complete <= 1'b0;
                end
            end
            if (accept) begin
                for (int l = 0; l < N; l++) begin
                    if (dispatch_valid[l]) begin
                        entries[dispatch_idxs[l]] <= alloc_entries[l];
                    end
                end
            end
            head  <= head + ROB_IDX'(retired);
            tail  <= tail + (accept ? ROB_IDX'(dispatched) : ROB_IDX'(0));
            count <= count + (accept ? dispatched : CW'(0)) - retired;
        end
    end

`ifdef ROB_PERF_CNT_EN
    logic [PERF_W-1:0] full_cnt;
    logic [PERF_W-1:0] flush_cnt;

    // Count full cycles and flushes, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            if (count == CW'(DEPTH)) begin
                full_cnt <= sat_inc(full_cnt);
            end
            if (mispredict) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    assign perf_full_cycles = full_cnt;
    assign perf_flushes     = flush_cnt;
`else
    assign perf_full_cycles = '0;
    assign perf_flushes     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rob.sv
// +------------------------------------------------------------------+
// | tb_rob                                                           |
// | Directed self-checking bench for rob with N=3, DEPTH=8.          |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
`include "sys_defs.svh"
`default_nettype none

module tb_rob;

    localparam int N     = 3;
    localparam int DEPTH = 8;

`ifdef ROB_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] dispatch_valid;
    ROB_ENTRY     dispatch_entries [N];
    logic         dispatch_ready;
    ROB_IDX       dispatch_idxs [N];
    logic [3:0]   free_slots;
    logic [N-1:0] complete_valid;
    ROB_IDX       complete_idxs [N];
    logic [N-1:0] complete_taken;
    ADDR          complete_target [N];
    ROB_ENTRY     head_entries [N];
    logic [N-1:0] head_valids;
    ROB_IDX       head_idxs [N];
    logic         mispredict;
    ROB_IDX       mispred_idx;
    logic [31:0]  perf_full_cycles;
    logic [31:0]  perf_flushes;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rob #(.N(N), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dispatch_valid   (dispatch_valid),
        .dispatch_entries (dispatch_entries),
        .dispatch_ready   (dispatch_ready),
        .dispatch_idxs    (dispatch_idxs),
        .free_slots       (free_slots),
        .complete_valid   (complete_valid),
        .complete_idxs    (complete_idxs),
        .complete_taken   (complete_taken),
        .complete_target  (complete_target),
        .head_entries     (head_entries),
        .head_valids      (head_valids),
        .head_idxs        (head_idxs),
        .mispredict       (mispredict),
        .mispred_idx      (mispred_idx),
        .perf_full_cycles (perf_full_cycles),
        .perf_flushes     (perf_flushes)
    );

    task automatic clear_inputs();
        dispatch_valid = '0;
        complete_valid = '0;
        complete_taken = '0;
        mispredict     = 1'b0;
        mispred_idx    = '0;
        for (int i = 0; i < N; i++) begin
            dispatch_entries[i] = '0;
            complete_idxs[i]    = '0;
            complete_target[i]  = '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        rst_n = 1'b1;
    endtask

    // Lane i carries pc = base + 4*i; the complete field is set to show it is ignored.
    task automatic drive_dispatch(input logic [N-1:0] v, input logic [31:0] base);
        dispatch_valid = v;
        for (int i = 0; i < N; i++) begin
            dispatch_entries[i]          = '0;
            dispatch_entries[i].pc       = base + 32'(4 * i);
            dispatch_entries[i].complete = 1'b1;
            dispatch_entries[i].dest_reg = 5'(i + 1);
        end
    endtask

    task automatic drive_complete(input logic [N-1:0] v, input int i0, input int i1, input int i2);
        complete_valid   = v;
        complete_idxs[0] = ROB_IDX'(i0);
        complete_idxs[1] = ROB_IDX'(i1);
        complete_idxs[2] = ROB_IDX'(i2);
    endtask

    task automatic test_reset();
        clear_inputs();
        #2;
        checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", dispatch_ready); end
        checks++; if (free_slots !== 4'd8) begin errors++; $display("FAIL reset_free: got %0d expected 8", free_slots); end
        checks++; if (head_valids !== 3'b000) begin errors++; $display("FAIL reset_hvalid: got %b expected 000", head_valids); end
        for (int i = 0; i < N; i++) begin
            checks++; if (head_entries[i] !== '0) begin errors++; $display("FAIL reset_hentry%0d: got %0h expected 0", i, head_entries[i]); end
            checks++; if (head_idxs[i] !== ROB_IDX'(i)) begin errors++; $display("FAIL reset_hidx%0d: got %0d expected %0d", i, head_idxs[i], i); end
            checks++; if (dispatch_idxs[i] !== '0) begin errors++; $display("FAIL reset_didx%0d: got %0d expected 0", i, dispatch_idxs[i]); end
        end
        checks++; if (perf_full_cycles !== 32'd0 || perf_flushes !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_full_cycles, perf_flushes); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_sparse_dispatch();
        do_reset();
        drive_dispatch(3'b101, 32'h100);
        #1;
        checks++; if (dispatch_idxs[0] !== 3'd0) begin errors++; $display("FAIL sparse_idx0: got %0d expected 0", dispatch_idxs[0]); end
        checks++; if (dispatch_idxs[2] !== 3'd1) begin errors++; $display("FAIL sparse_idx2: got %0d expected 1", dispatch_idxs[2]); end
        checks++; if (dispatch_idxs[1] !== 3'd0) begin errors++; $display("FAIL sparse_idx1: got %0d expected 0", dispatch_idxs[1]); end
        step(); clear_inputs(); #1;
        checks++; if (head_valids !== 3'b011) begin errors++; $display("FAIL sparse_hvalid: got %b expected 011", head_valids); end
        checks++; if (free_slots !== 4'd6) begin errors++; $display("FAIL sparse_free: got %0d expected 6", free_slots); end
        checks++; if (head_entries[0].pc !== 32'h100) begin errors++; $display("FAIL sparse_pc0: got %0h expected 100", head_entries[0].pc); end
        checks++; if (head_entries[1].pc !== 32'h108) begin errors++; $display("FAIL sparse_pc1: got %0h expected 108", head_entries[1].pc); end
        checks++; if (head_entries[0].complete !== 1'b0) begin errors++; $display("FAIL sparse_cmpl0: got %0b expected 0", head_entries[0].complete); end
        checks++; if (head_entries[2] !== '0) begin errors++; $display("FAIL sparse_hentry2: got %0h expected 0", head_entries[2]); end
        // completion to idx 1 is not visible until after the write edge
        drive_complete(3'b001, 1, 0, 0);
        complete_taken[0]  = 1'b1;
        complete_target[0] = 32'hABC;
        #1;
        checks++; if (head_entries[1].complete !== 1'b0) begin errors++; $display("FAIL nobypass: got %0b expected 0", head_entries[1].complete); end
        step(); clear_inputs(); #1;
        checks++; if (head_entries[1].complete !== 1'b1) begin errors++; $display("FAIL cmpl_write: got %0b expected 1", head_entries[1].complete); end
        checks++; if (head_entries[1].branch_target !== 32'hABC || head_entries[1].branch_taken !== 1'b1) begin errors++; $display("FAIL cmpl_branch: got %0b/%0h expected 1/abc", head_entries[1].branch_taken, head_entries[1].branch_target); end
        checks++; if (free_slots !== 4'd6) begin errors++; $display("FAIL cmpl_noretire: got %0d expected 6", free_slots); end
        drive_complete(3'b001, 0, 0, 0);
        step(); clear_inputs();
        step();
        checks++; if (free_slots !== 4'd8 || head_valids !== 3'b000) begin errors++; $display("FAIL sparse_drain: got %0d/%b expected 8/000", free_slots, head_valids); end
        checks++; if (head_idxs[0] !== 3'd2) begin errors++; $display("FAIL sparse_head: got %0d expected 2", head_idxs[0]); end
    endtask

    task automatic test_full();
        do_reset();
        drive_dispatch(3'b111, 32'h200); step();
        drive_dispatch(3'b011, 32'h210); step();
        drive_dispatch(3'b111, 32'h220); #1;
        checks++; if (dispatch_ready !== 1'b1) begin errors++; $display("FAIL full_ready3: got %0b expected 1", dispatch_ready); end
        step(); clear_inputs(); #1;
        checks++; if (dispatch_ready !== 1'b0 || free_slots !== 4'd0) begin errors++; $display("FAIL full_state: got %0b/%0d expected 0/0", dispatch_ready, free_slots); end
        drive_dispatch(3'b111, 32'h300); step(); clear_inputs(); #1;
        checks++; if (free_slots !== 4'd0 || head_idxs[0] !== 3'd0) begin errors++; $display("FAIL full_ignore: got %0d/%0d expected 0/0", free_slots, head_idxs[0]); end
        drive_complete(3'b011, 0, 1, 0); step(); clear_inputs();
        // retire of 2 happens now; a dispatch offered in the same cycle is refused
        drive_dispatch(3'b111, 32'h310); step(); clear_inputs(); #1;
        checks++; if (free_slots !== 4'd2 || dispatch_ready !== 1'b0) begin errors++; $display("FAIL full_retire2: got %0d/%0b expected 2/0", free_slots, dispatch_ready); end
        checks++; if (head_idxs[0] !== 3'd2) begin errors++; $display("FAIL full_head2: got %0d expected 2", head_idxs[0]); end
        checks++; if (perf_full_cycles !== (PERF_ON ? 32'd3 : 32'd0)) begin errors++; $display("FAIL perf_full: got %0d expected %0d", perf_full_cycles, PERF_ON ? 3 : 0); end
        drive_complete(3'b111, 2, 3, 4); step(); clear_inputs();
        step();
        checks++; if (free_slots !== 4'd5 || dispatch_ready !== 1'b1) begin errors++; $display("FAIL full_retire3: got %0d/%0b expected 5/1", free_slots, dispatch_ready); end
        drive_dispatch(3'b111, 32'h400); #1;
        checks++; if (dispatch_idxs[0] !== 3'd0 || dispatch_idxs[1] !== 3'd1 || dispatch_idxs[2] !== 3'd2) begin errors++; $display("FAIL tail_wrap: got %0d,%0d,%0d expected 0,1,2", dispatch_idxs[0], dispatch_idxs[1], dispatch_idxs[2]); end
        step(); clear_inputs(); #1;
        checks++; if (free_slots !== 4'd2) begin errors++; $display("FAIL full_refill: got %0d expected 2", free_slots); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive_dispatch(3'b111, 32'h500); step();
        drive_dispatch(3'b111, 32'h510); step(); clear_inputs();
        drive_complete(3'b111, 0, 1, 2); step();
        drive_complete(3'b111, 3, 4, 5); step(); clear_inputs();
        step();
        drive_dispatch(3'b111, 32'h600); #1;
        checks++; if (dispatch_idxs[0] !== 3'd6 || dispatch_idxs[1] !== 3'd7 || dispatch_idxs[2] !== 3'd0) begin errors++; $display("FAIL wrap_didx: got %0d,%0d,%0d expected 6,7,0", dispatch_idxs[0], dispatch_idxs[1], dispatch_idxs[2]); end
        step();
        drive_dispatch(3'b001, 32'h610); #1;
        checks++; if (dispatch_idxs[0] !== 3'd1) begin errors++; $display("FAIL wrap_didx1: got %0d expected 1", dispatch_idxs[0]); end
        step(); clear_inputs(); #1;
        checks++; if (free_slots !== 4'd4 || head_idxs[0] !== 3'd6 || head_idxs[2] !== 3'd0) begin errors++; $display("FAIL wrap_setup: got %0d/%0d/%0d expected 4/6/0", free_slots, head_idxs[0], head_idxs[2]); end
        drive_complete(3'b111, 6, 7, 0); step(); clear_inputs(); #1;
        checks++; if ({head_entries[2].complete, head_entries[1].complete, head_entries[0].complete} !== 3'b111) begin errors++; $display("FAIL wrap_cmpl: got %b expected 111", {head_entries[2].complete, head_entries[1].complete, head_entries[0].complete}); end
        step();
        checks++; if (head_idxs[0] !== 3'd1 || free_slots !== 4'd7 || head_valids !== 3'b001) begin errors++; $display("FAIL wrap_retire: got %0d/%0d/%b expected 1/7/001", head_idxs[0], free_slots, head_valids); end
    endtask

    task automatic test_partial_complete();
        do_reset();
        drive_dispatch(3'b111, 32'h700); step(); clear_inputs();
        drive_complete(3'b011, 0, 1, 0); step(); clear_inputs();
        step();
        drive_dispatch(3'b011, 32'h710); #1;
        checks++; if (dispatch_idxs[0] !== 3'd3 || dispatch_idxs[1] !== 3'd4) begin errors++; $display("FAIL part_didx: got %0d,%0d expected 3,4", dispatch_idxs[0], dispatch_idxs[1]); end
        step(); clear_inputs();
        drive_complete(3'b001, 3, 0, 0); step(); clear_inputs(); #1;
        checks++; if (head_entries[1].complete !== 1'b1 || head_entries[0].complete !== 1'b0) begin errors++; $display("FAIL part_bits: got %0b%0b expected 10", head_entries[1].complete, head_entries[0].complete); end
        step();
        checks++; if (head_idxs[0] !== 3'd2 || free_slots !== 4'd5) begin errors++; $display("FAIL part_noretire: got %0d/%0d expected 2/5", head_idxs[0], free_slots); end
        // two lanes hit idx 4; lane 2 must win
        drive_complete(3'b101, 4, 0, 4);
        complete_target[0] = 32'h111;
        complete_target[2] = 32'h222;
        step(); clear_inputs(); #1;
        checks++; if (head_entries[2].branch_target !== 32'h222) begin errors++; $display("FAIL dup_lane: got %0h expected 222", head_entries[2].branch_target); end
        drive_complete(3'b001, 2, 0, 0); step(); clear_inputs();
        step();
        checks++; if (head_idxs[0] !== 3'd5 || free_slots !== 4'd8) begin errors++; $display("FAIL part_drain: got %0d/%0d expected 5/8", head_idxs[0], free_slots); end
    endtask

    task automatic test_mispredict();
        do_reset();
        drive_dispatch(3'b111, 32'h800); step();
        drive_dispatch(3'b011, 32'h810); step(); clear_inputs(); #1;
        checks++; if (free_slots !== 4'd3 || dispatch_ready !== 1'b1) begin errors++; $display("FAIL mp_setup: got %0d/%0b expected 3/1", free_slots, dispatch_ready); end
        mispredict  = 1'b1;
        mispred_idx = 3'd5;
        drive_dispatch(3'b111, 32'h820);
        drive_complete(3'b001, 0, 0, 0);
        step(); clear_inputs(); #1;
        checks++; if (free_slots !== 4'd8 || head_valids !== 3'b000 || head_idxs[0] !== 3'd6) begin errors++; $display("FAIL mp_flush: got %0d/%b/%0d expected 8/000/6", free_slots, head_valids, head_idxs[0]); end
        checks++; if (perf_flushes !== (PERF_ON ? 32'd1 : 32'd0)) begin errors++; $display("FAIL perf_flush: got %0d expected %0d", perf_flushes, PERF_ON ? 1 : 0); end
        drive_dispatch(3'b001, 32'h830); #1;
        checks++; if (dispatch_idxs[0] !== 3'd6) begin errors++; $display("FAIL mp_tail: got %0d expected 6", dispatch_idxs[0]); end
        step(); clear_inputs(); #1;
        checks++; if (head_valids !== 3'b001 || free_slots !== 4'd7 || head_entries[0].pc !== 32'h830) begin errors++; $display("FAIL mp_after: got %b/%0d/%0h expected 001/7/830", head_valids, free_slots, head_entries[0].pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_dispatch(3'b111, 32'h900); step(); clear_inputs(); #1;
        checks++; if (head_valids !== 3'b111) begin errors++; $display("FAIL ar_setup: got %b expected 111", head_valids); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (head_valids !== 3'b000 || free_slots !== 4'd8) begin errors++; $display("FAIL ar_immediate: got %b/%0d expected 000/8", head_valids, free_slots); end
        checks++; if (perf_full_cycles !== 32'd0 || perf_flushes !== 32'd0) begin errors++; $display("FAIL ar_perf: got %0d/%0d expected 0/0", perf_full_cycles, perf_flushes); end
        #2;
        drive_dispatch(3'b111, 32'hA00);
        #1;
        rst_n = 1'b1;
        step(); clear_inputs(); #1;
        checks++; if (head_valids !== 3'b111 || free_slots !== 4'd5 || head_entries[0].pc !== 32'hA00) begin errors++; $display("FAIL ar_first_edge: got %b/%0d/%0h expected 111/5/a00", head_valids, free_slots, head_entries[0].pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_dispatch(3'b111, 32'hB00); step();
        drive_dispatch(3'b111, 32'hB10);
        drive_complete(3'b111, 0, 1, 2); #1;
        checks++; if (dispatch_idxs[0] !== 3'd3 || dispatch_idxs[2] !== 3'd5) begin errors++; $display("FAIL b2b_didx: got %0d,%0d expected 3,5", dispatch_idxs[0], dispatch_idxs[2]); end
        step(); clear_inputs();
        drive_complete(3'b111, 3, 4, 5); #1;
        checks++; if (dispatch_ready !== 1'b0) begin errors++; $display("FAIL b2b_notready: got %0b expected 0", dispatch_ready); end
        step(); clear_inputs(); #1;
        checks++; if (free_slots !== 4'd5) begin errors++; $display("FAIL b2b_free: got %0d expected 5", free_slots); end
        drive_dispatch(3'b111, 32'hB20); #1;
        checks++; if (dispatch_idxs[0] !== 3'd6 || dispatch_idxs[2] !== 3'd0) begin errors++; $display("FAIL b2b_wrap: got %0d,%0d expected 6,0", dispatch_idxs[0], dispatch_idxs[2]); end
        step(); clear_inputs(); #1;
        checks++; if (free_slots !== 4'd5 || head_idxs[0] !== 3'd6 || head_valids !== 3'b111) begin errors++; $display("FAIL b2b_state: got %0d/%0d/%b expected 5/6/111", free_slots, head_idxs[0], head_valids); end
        checks++; if (head_entries[2].pc !== 32'hB28) begin errors++; $display("FAIL b2b_pc: got %0h expected b28", head_entries[2].pc); end
    endtask

    initial begin
        test_reset();
        test_sparse_dispatch();
        test_full();
        test_wrap();
        test_partial_complete();
        test_mispredict();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter N, default `N, dispatch/complete/head window width.
REQ-002 Parameter DEPTH, default `ROB_SZ, entry count, power of two and >= 2*N.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous active-low reset, asserted at 0.
REQ-005 dispatch_valid  input  N  per-lane allocate request, lanes may be sparse.
REQ-006 dispatch_entries  input  ROB_ENTRY[N]  entry contents for each lane; complete field ignored.
REQ-007 dispatch_ready  output  1  high when free_slots >= N.
REQ-008 dispatch_idxs  output  ROB_IDX[N]  index assigned to each valid lane this cycle.
REQ-009 free_slots  output  $clog2(DEPTH)+1  DEPTH minus registered occupancy.
REQ-010 complete_valid  input  N  per-lane completion write.
REQ-011 complete_idxs  input  ROB_IDX[N]  target entry of each completion.
REQ-012 complete_taken / complete_target  input  N / ADDR[N]  resolved branch outcome.
REQ-013 head_entries / head_valids / head_idxs  output  ROB_ENTRY[N] / N / ROB_IDX[N]  oldest-first window, slot 0 oldest.
REQ-014 mispredict / mispred_idx  input  1 / ROB_IDX  retire-time flush request and index of mispredicted branch.
REQ-015 perf_full_cycles / perf_flushes  output  32 / 32  performance counters, present per REQ-036.

Function
REQ-016 Storage is a circular buffer with head, tail, and occupancy count registers; indices wrap modulo DEPTH.
REQ-017 Valid dispatch lanes receive consecutive indices from tail in ascending lane order; invalid lanes get no index and do not consume slots.
REQ-018 Dispatch is accepted only when dispatch_ready=1; with dispatch_ready=0, dispatch_valid is ignored and state is unchanged.
REQ-019 dispatch_ready and free_slots are computed from registered count only; same-cycle retires do not contribute.
REQ-020 Dispatched entries are written with complete=0 and are visible on head outputs one cycle later at the earliest.
REQ-021 A completion sets complete=1, branch_taken, and branch_target of a valid entry; a completion to an invalid entry is dropped.
REQ-022 Duplicate complete_idxs in one cycle resolve in favour of the highest lane.
REQ-023 Head slot w presents entry (head+w) mod DEPTH, with head_valids[w] = (w < count); invalid slots drive all-zero entries.
REQ-024 Retire count is the number of leading head slots that are valid and complete, stopping at the first incomplete slot; this mirrors the consumer's commit rule.
REQ-025 Without mispredict, head advances by the retire count, and count updates to count + dispatched - retired in the same edge.
REQ-026 When mispredict=1, all entries are invalidated, head=tail=(mispred_idx+1) mod DEPTH, and count=0 at the next edge.
REQ-027 When mispredict=1, same-cycle dispatch and completions are discarded.
REQ-028 Completions are written to storage; head outputs reflect them the cycle after the write, with no bypass.
REQ-029 count shall never exceed DEPTH or go below 0; wrap of head/tail past DEPTH-1 returns to 0.
REQ-030 A full buffer (count=DEPTH) with simultaneous retire of k entries shall not accept dispatch that cycle; dispatch_ready rises the next cycle if DEPTH-(DEPTH-k) >= N.

Reset
REQ-031 While reset=0: head=tail=0, count=0, all entry valid/complete bits cleared, and perf counters cleared.
REQ-032 Outputs during reset: dispatch_ready=1, free_slots=DEPTH, head_valids=0, head_entries=0, head_idxs={0..N-1}, dispatch_idxs=0.
REQ-033 Reset asserted mid-operation discards all in-flight entries immediately, with no dependence on clock.
REQ-034 The first edge after reset release accepts dispatch normally.

Configuration
REQ-035 Macro ROB_PERF_CNT_EN selects the performance counters.
REQ-036 With ROB_PERF_CNT_EN defined: perf_full_cycles increments in each cycle with count=DEPTH, perf_flushes increments on each mispredict, both saturate at 2^32-1.
REQ-037 Without ROB_PERF_CNT_EN: both ports remain and are tied to 0, and no counter flops exist.

Structure
REQ-038 ROB_ENTRY, ROB_IDX, ADDR, and `ROB_SZ live in sys_defs.svh; no new package types are added.
REQ-039 One sub-module, rob_alloc, computes the per-lane prefix-sum index allocation and dispatched count from dispatch_valid and tail.

Verification (N=3, DEPTH=8)
REQ-040 After reset, dispatch 3'b101 -> dispatch_idxs lane0=0, lane2=1; next cycle head_valids=3'b011 and free_slots=6.
REQ-041 Fill to 8 entries -> dispatch_ready=0 and free_slots=0; complete idx 0,1 -> 2 retire, then free_slots=2 and dispatch_ready stays 0.
REQ-042 Head=6, count=4, complete idx 6,7,0 -> retire 3, head=1 (wrap), count=1.
REQ-043 Complete idx 3 but not 2 with head=2 -> retire 0 and head unchanged.
REQ-044 Mispredict with mispred_idx=5 and simultaneous dispatch -> next cycle count=0, head=tail=6, and head_valids=0.
REQ-045 Assert reset for half a cycle mid-traffic -> head_valids=0 immediately; with ROB_PERF_CNT_EN defined, both counters read 0.
